// File: rtl/mask_pixel_stream.sv
// mask_pixel_stream: thresholds one 8-bit channel into sparse hit coordinates plus an end-of-window tabulate pulse.
// Optional run-length hit filter enabled by defining RUN_FILTER_EN.
module mask_pixel_stream #(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int FRAME_DIV = 1
`ifdef RUN_FILTER_EN
    ,
    parameter int RUN_LEN   = 3
`endif
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [7:0]  channel_in,
    input  logic        data_valid_in,
    input  logic [7:0]  lo_in,
    input  logic [7:0]  hi_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        mask_out,
    output logic        tabulate_out,
    output logic [20:0] hit_count_out
);

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [3:0]  F_LAST = 4'(FRAME_DIV - 1);

    logic [7:0]  lo_sh, hi_sh, lo_eff, hi_eff;
    logic        started, in_range, at_origin, at_end, hit, emit;
    logic        s1_hit, s1_emit, s1_end, s2_end, tab_next, emit2;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;
    logic [3:0]  fcnt;
    logic [20:0] acc;

    assign in_range  = data_valid_in && hcount_in <= H_LAST && vcount_in <= V_LAST;
    assign at_origin = in_range && hcount_in == 11'd0 && vcount_in == 10'd0;
    // The origin pixel already sees the thresholds being captured on it.
    assign lo_eff    = at_origin ? lo_in : lo_sh;
    assign hi_eff    = at_origin ? hi_in : hi_sh;
    assign hit       = in_range && channel_in >= lo_eff && channel_in <= hi_eff;
    assign at_end    = in_range && hcount_in == H_LAST && vcount_in == V_LAST && (started || at_origin);
    assign tab_next  = s2_end && fcnt == F_LAST;
    assign emit2     = s1_emit && !tab_next;

`ifdef RUN_FILTER_EN
    localparam logic [3:0] RUN_MIN = 4'(RUN_LEN);
    logic [3:0] run, run_base, run_inc;
    assign run_base = (hcount_in == 11'd0) ? 4'd0 : run;
    assign run_inc  = (run_base == 4'd15) ? 4'd15 : run_base + 4'd1;
    assign emit     = hit && run_inc >= RUN_MIN;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            run <= 4'd0;
        else if (in_range)
            run <= hit ? run_inc : 4'd0;
        else if (hcount_in == 11'd0)
            run <= 4'd0;
    end
`else
    assign emit = hit;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lo_sh         <= 8'hFF;
            hi_sh         <= 8'h00;
            started       <= 1'b0;
            s1_hit        <= 1'b0;
            s1_emit       <= 1'b0;
            s1_end        <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            s2_end        <= 1'b0;
            valid_out     <= 1'b0;
            mask_out      <= 1'b0;
            x_out         <= '0;
            y_out         <= '0;
            tabulate_out  <= 1'b0;
            fcnt          <= '0;
            acc           <= '0;
            hit_count_out <= '0;
        end else begin
            if (at_origin) begin
                lo_sh   <= lo_in;
                hi_sh   <= hi_in;
                started <= 1'b1;
            end
            s1_hit    <= hit;
            s1_emit   <= emit;
            s1_end    <= at_end;
            s1_x      <= hcount_in;
            s1_y      <= vcount_in;
            s2_end    <= s1_end;
            valid_out <= emit2;
            mask_out  <= s1_hit;
            if (emit2) begin
                x_out <= s1_x;
                y_out <= s1_y;
            end
            tabulate_out <= tab_next;
            if (s2_end)
                fcnt <= tab_next ? 4'd0 : fcnt + 4'd1;
            if (tab_next)
                hit_count_out <= acc;
            // A hit colliding with tabulate is dropped, so the clear never races a count.
            acc <= tab_next ? '0 : (emit2 && acc != '1) ? acc + 21'd1 : acc;
        end
    end

endmodule

// File: tb/tb_mask_pixel_stream.sv
// tb_mask_pixel_stream: randomized/directed frames checked against a cycle-indexed behavioural model.
module tb_mask_pixel_stream;
    localparam int H = 16, V = 8, FD = 3, RL = 3, N = 8192;

    logic        clk_in = 1'b0, rst_n_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic [7:0]  channel_in = '0, lo_in = '0, hi_in = '0;
    logic        data_valid_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out, mask_out, tabulate_out;
    logic [20:0] hit_count_out;

    always #5 clk_in = ~clk_in;

    mask_pixel_stream #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_DIV(FD)
`ifdef RUN_FILTER_EN
        , .RUN_LEN(RL)
`endif
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .channel_in(channel_in), .data_valid_in(data_valid_in), .lo_in(lo_in), .hi_in(hi_in),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .mask_out(mask_out),
        .tabulate_out(tabulate_out), .hit_count_out(hit_count_out)
    );

    // Expected outputs indexed by the clock count at which they must be visible.
    bit ev[N], em[N], et[N];
    int ex[N], ey[N];
    int cyc, compared, mism;
    int m_lo, m_hi, m_frames, m_run, acc_m, exp_hc, exp_x, exp_y;
    bit m_started;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        if (et[cyc]) ev[cyc] = 1'b0;
        if (ev[cyc]) begin
            exp_x = ex[cyc];
            exp_y = ey[cyc];
        end
        chk("valid", 32'(valid_out), 32'(ev[cyc]));
        chk("mask", 32'(mask_out), 32'(em[cyc]));
        chk("tabulate", 32'(tabulate_out), 32'(et[cyc]));
        chk("x", 32'(x_out), exp_x);
        chk("y", 32'(y_out), exp_y);
        if (et[cyc]) begin
            exp_hc = acc_m;
            acc_m  = 0;
        end else if (ev[cyc] && acc_m < 2097151) acc_m++;
        chk("hit_count", 32'(hit_count_out), exp_hc);
    endtask

    task automatic model(input int dv, input int h, input int v, input int ch, input int lo, input int hi);
        bit hit, emit;
        int p = cyc;
        if (h == 0) m_run = 0;
        if (!(dv != 0 && h < H && v < V)) return;
        if (h == 0 && v == 0) begin
            m_lo = lo;
            m_hi = hi;
            m_started = 1'b1;
        end
        hit = ch >= m_lo && ch <= m_hi;
        emit = hit;
`ifdef RUN_FILTER_EN
        m_run = hit ? (m_run < 15 ? m_run + 1 : 15) : 0;
        emit = hit && m_run >= RL;
`endif
        em[p+2] = hit;
        if (emit) begin
            ev[p+2] = 1'b1;
            ex[p+2] = h;
            ey[p+2] = v;
        end
        if (h == H - 1 && v == V - 1 && m_started) begin
            m_frames++;
            if (m_frames == FD) begin
                m_frames = 0;
                et[p+3] = 1'b1;
            end
        end
    endtask

    task automatic step(input int dv, input int h, input int v, input int ch, input int lo, input int hi);
        check_cycle();
        data_valid_in = dv[0];
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        channel_in = 8'(ch);
        lo_in = 8'(lo);
        hi_in = 8'(hi);
        model(dv, h, v, ch, lo, hi);
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        data_valid_in = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_mask", 32'(mask_out), 0);
        chk("rst_tab", 32'(tabulate_out), 0);
        chk("rst_x", 32'(x_out), 0);
        chk("rst_y", 32'(y_out), 0);
        chk("rst_count", 32'(hit_count_out), 0);
        for (int i = cyc; i < N; i++) begin
            ev[i] = 1'b0; em[i] = 1'b0; et[i] = 1'b0;
        end
        m_lo = 255; m_hi = 0; m_started = 1'b0; m_frames = 0; m_run = 0;
        acc_m = 0; exp_hc = 0; exp_x = 0; exp_y = 0;
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    function automatic int chan(input int mode, input int h, input int v);
        case (mode)
            0: return (h == 6 && v == 3) ? 100 : 0;
            1: return (v == 2 && h == 0) ? 99 : (v == 2 && h == 1) ? 100 :
                      (v == 2 && h == 2) ? 120 : (v == 2 && h == 3) ? 121 : 0;
            3: return (v == 0 && h < 10) ? 110 : 0;
            4: return ((v == 5 && h >= 3 && h <= 7) || (v == 6 && h >= H - 2) || (v == 7 && h < 2)) ? 110 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic frame(input int lo, input int hi, input int mode, input int hb, input int bub,
                         input int chg_row, input int lo2, input int hi2, input int rst_row);
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H + hb; h++) begin
                if (v == rst_row && h == 0) do_reset();
                while (bub != 0 && $urandom_range(0, 7) == 0)
                    step(0, h, v, int'($urandom_range(0, 255)), lo, hi);
                step(1, h, v, chan(mode, h, v), v >= chg_row ? lo2 : lo, v >= chg_row ? hi2 : hi);
            end
        for (int k = 0; k < 2 * hb; k++) step(1, k, V, int'($urandom_range(0, 255)), lo, hi);
    endtask

    initial begin
        do_reset();
        repeat (3) frame(100, 120, 0, 4, 0, 99, 0, 0, -1);
        repeat (3) frame(100, 120, 1, 4, 0, 99, 0, 0, -1);
        repeat (3) frame(200, 10, 2, 4, 1, 99, 0, 0, -1);
        frame(100, 120, 2, 4, 1, 4, 0, 255, -1);
        frame(0, 255, 2, 4, 0, 99, 0, 0, -1);
        frame(30, 60, 2, 4, 1, 2, 250, 255, -1);
        do_reset();
        repeat (4) frame(100, 120, 3, 0, 0, 99, 0, 0, -1);
        frame(100, 120, 0, 4, 0, 99, 0, 0, 5);
        repeat (3) frame(100, 120, 0, 4, 0, 99, 0, 0, -1);
        repeat (3) frame(100, 120, 4, 4, 0, 99, 0, 0, -1);
        repeat (3) frame(80, 180, 2, 2, 1, 99, 0, 0, -1);
        repeat (6) step(0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
